// File: rtl/cwiczenia_counter.sv
// cwiczenia_counter
// Free-running WIDTH-bit up-counter used as the timebase for a 4-digit
// multiplexed display. The top two counter bits select the active digit,
// a registered active-low one-hot enable drives the digit anodes, and a
// single-cycle tick marks every full counter period.
//
// Build option: define CWICZENIA_SCAN_EN to generate the tick and
// digit-scan logic. Without it only the counter exists; tick, sel and an_n
// are tied to their idle values (0, 2'b00, 4'b1111) and the port list is
// identical in both builds.

module cwiczenia_counter #(
  parameter  int unsigned WIDTH  = 22,
  localparam int unsigned DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WIDTH-1:0]  cnt,
  output logic              tick,
  output logic [1:0]        sel,
  output logic [DIGITS-1:0] an_n
);

  // Digit selection uses exactly the top two counter bits, so the counter
  // must be wide enough to leave at least one bit of dwell time per digit.
  initial begin : g_param_check
    assert (WIDTH >= 3 && WIDTH <= 32)
      else $fatal(1, "cwiczenia_counter: WIDTH must be in 3..32");
  end

  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [DIGITS-1:0] AN_OFF  = '1;

  // ---------------------------------------------------------------------
  // Counter
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: plain modulo-2^WIDTH increment, no enable, no saturation.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
  end

  // Counter register, cleared asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

`ifdef CWICZENIA_SCAN_EN
  // ---------------------------------------------------------------------
  // Wrap pulse and digit scan
  // ---------------------------------------------------------------------
  logic              tick_q;
  logic              tick_d;
  logic [DIGITS-1:0] an_q;
  logic [DIGITS-1:0] an_d;
  logic [1:0]        sel_next;

  // Tick fires on the edge where the counter rolls from all-ones to zero.
  always_comb begin
    tick_d = (cnt_q == CNT_ONES);
  end

  // Decode the digit enable from the *next* count so the registered an_n
  // changes on the same edge as sel (which is taken straight from cnt).
  always_comb begin
    // NOTE: assign a default before the case so every path drives an_d;
    // otherwise an incomplete branch would infer a latch.
    an_d     = AN_OFF;
    sel_next = cnt_d[WIDTH-1 -: 2];
    case (sel_next)
      2'd0:    an_d = 4'b1110;
      2'd1:    an_d = 4'b1101;
      2'd2:    an_d = 4'b1011;
      2'd3:    an_d = 4'b0111;
      default: an_d = AN_OFF;
    endcase
  end

  // Tick and anode registers; reset blanks all digits.
  // NOTE: these are control flops, not storage, so they take the async
  // clear; a visible "all off" state during reset is part of the contract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      an_q   <= AN_OFF;
    end else begin
      tick_q <= tick_d;
      an_q   <= an_d;
    end
  end

  assign tick = tick_q;
  assign sel  = cnt_q[WIDTH-1 -: 2];
  assign an_n = an_q;
`else
  // Scan disabled: outputs held at their idle values.
  assign tick = 1'b0;
  assign sel  = 2'b00;
  assign an_n = AN_OFF;
`endif

endmodule

// File: tb/tb_cwiczenia_counter.sv
// Directed bench for cwiczenia_counter: a WIDTH=22 instance exercises
// reset, release and asynchronous mid-count reset; a WIDTH=4 instance
// exercises wrap, tick and the digit scan. Expectations follow the build
// option CWICZENIA_SCAN_EN (idle outputs when it is undefined).

module tb_cwiczenia_counter;

`ifdef CWICZENIA_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic [21:0] cnt_w;
  logic        tick_w;
  logic [1:0]  sel_w;
  logic [3:0]  an_w;

  logic [3:0]  cnt_n;
  logic        tick_n;
  logic [1:0]  sel_n;
  logic [3:0]  an_n4;

  int checks   = 0;
  int failures = 0;

  // Hand-written anode table indexed by digit.
  logic [3:0] an_tab [4];

  cwiczenia_counter #(.WIDTH(22)) u_wide (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt_w),
    .tick  (tick_w),
    .sel   (sel_w),
    .an_n  (an_w)
  );

  cwiczenia_counter #(.WIDTH(4)) u_narrow (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt_n),
    .tick  (tick_n),
    .sel   (sel_n),
    .an_n  (an_n4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int digit);
    return SCAN ? an_tab[digit] : 4'b1111;
  endfunction

  initial begin
    an_tab[0] = 4'b1110;
    an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011;
    an_tab[3] = 4'b0111;

    // Step 1: hold reset for 5 clocks.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_cnt",   32'(cnt_w),  32'd0);
    check("rst_tick",  32'(tick_w), 32'd0);
    check("rst_sel",   32'(sel_w),  32'd0);
    check("rst_an",    32'(an_w),   32'hf);
    check("rst_cnt4",  32'(cnt_n),  32'd0);
    check("rst_an4",   32'(an_n4),  32'hf);

    // Step 2: release; one edge later cnt=1 and digit 0 is lit.
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_cnt", 32'(cnt_w), 32'd1);
    check("rel1_an",  32'(an_w),  32'(exp_an(0)));

    // Step 3: ten clocks after release cnt=10.
    repeat (9) @(negedge clk);
    check("rel10_cnt", 32'(cnt_w), 32'd10);
    check("rel10_sel", 32'(sel_w), 32'd0);

    // Step 4: run to cnt=1000, then reset between edges.
    repeat (990) @(negedge clk);
    check("c1000_cnt", 32'(cnt_w), 32'd1000);
    #2 rst_n = 1'b0;
    #1;
    check("async_cnt",  32'(cnt_w),  32'd0);
    check("async_an",   32'(an_w),   32'hf);
    check("async_tick", 32'(tick_w), 32'd0);
    @(negedge clk);
    check("async_hold_cnt", 32'(cnt_w), 32'd0);

    // Step 5: release and walk the WIDTH=4 instance through one wrap.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("wrap_cnt4_%0d", k), 32'(cnt_n), 32'(k % 16));
      check($sformatf("wrap_tick_%0d", k), 32'(tick_n),
            32'((k == 16) && SCAN));
      check($sformatf("wrap_sel_%0d", k), 32'(sel_n),
            SCAN ? 32'((k % 16) / 4) : 32'd0);
      check($sformatf("wrap_an_%0d", k), 32'(an_n4),
            32'(exp_an((k % 16) / 4)));
      check($sformatf("wrap_onehot_%0d", k), 32'($countones(~an_n4)),
            SCAN ? 32'd1 : 32'd0);
      check($sformatf("wrap_cnt22_%0d", k), 32'(cnt_w), 32'(k));
    end

    // Step 6: cycle after the wrap: tick drops, counting resumes.
    @(negedge clk);
    check("post_wrap_cnt4", 32'(cnt_n),  32'd1);
    check("post_wrap_tick", 32'(tick_n), 32'd0);
    check("post_wrap_an",   32'(an_n4),  32'(exp_an(0)));
    check("wide_tick_idle", 32'(tick_w), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
